// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared constants for the time-of-day core: edit-field indices, field
// widths, wrap limits and the 24h -> 12h display mapping helper.
// ---------------------------------------------------------------------------
package clock_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    // cursor_pos encodings
    localparam logic [1:0] FLD_SEC  = 2'd0;
    localparam logic [1:0] FLD_MIN  = 2'd1;
    localparam logic [1:0] FLD_HOUR = 2'd2;
    localparam logic [1:0] FLD_NONE = 2'd3;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [HOUR_W-1:0] NOON     = 5'd12;

    // Number of advances an unacknowledged alarm stays asserted.
    localparam logic [5:0] ALARM_ADVANCES = 6'd60;

    // 0 -> 12, 1..12 unchanged, 13..23 -> 1..11
    function automatic logic [HOUR_W-1:0] to_hour12(input logic [HOUR_W-1:0] h24);
        logic [HOUR_W-1:0] h12;
        h12 = h24;
        if (h24 == '0) begin
            h12 = NOON;
        end else if (h24 > NOON) begin
            h12 = h24 - NOON;
        end
        return h12;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// Modulo (MAX+1) up/down counter used for every time and alarm field.
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   inc, dec    : step up / down by one this cycle (both high = hold)
//   clr         : synchronous clear, wins over inc/dec
//   val         : registered count, 0..MAX
//   carry       : combinational, high when an increment wraps MAX -> 0
// ---------------------------------------------------------------------------
module wrap_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] val,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (inc && !dec) begin
            val_d = (val_q == MAX_V) ? '0 : val_q + 1'b1;
        end else if (dec && !inc) begin
            val_d = (val_q == '0) ? MAX_V : val_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val   = val_q;
    assign carry = inc & ~dec & ~clr & (val_q == MAX_V);

endmodule

// File: rtl/clock_time_core.sv
// ---------------------------------------------------------------------------
// clock_time_core
// Time-of-day keeper: prescaler from CLK_HZ down to TICK_HZ advances,
// hh:mm:ss with carries, per-field up/down editing, synchronous clear,
// 12/24-hour display mapping and an optional alarm.
//
// Build option: define CLOCK_TIME_CORE_ALARM_EN to include the alarm
// (alarm registers, compare, ack/arm/timeout). Without it the alarm ports
// remain, outputs read 0 and alarm inputs are ignored.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   mode12          : 1 = 12-hour display, 0 = 24-hour display
//   up, down        : single-cycle edit pulses
//   clr             : synchronous clear of time, prescaler, pending advance
//   cursor_pos      : edit field (0 sec, 1 min, 2 hour, 3 none)
//   alarm_edit      : steer edits to the alarm registers
//   alarm_arm       : alarm enable
//   alarm_ack       : silence the alarm
//   second, minute  : registered time fields
//   hour, pm        : display hour (mapped by mode12) and afternoon flag
//   tick            : one-cycle pulse in the cycle after each advance
//   alarm           : alarm active
//   alarm_hour/min  : alarm set point (24-hour)
// ---------------------------------------------------------------------------
module clock_time_core
    import clock_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode12,
    input  logic              up,
    input  logic              down,
    input  logic              clr,
    input  logic [1:0]        cursor_pos,
    input  logic              alarm_edit,
    input  logic              alarm_arm,
    input  logic              alarm_ack,
    output logic [SEC_W-1:0]  second,
    output logic [MIN_W-1:0]  minute,
    output logic [HOUR_W-1:0] hour,
    output logic              pm,
    output logic              tick,
    output logic              alarm,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_minute
);

    // CLK_HZ / TICK_HZ must be an integer >= 2.
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_TC = PW'(DIV - 1);

    logic [SEC_W-1:0]  sec_val;
    logic [MIN_W-1:0]  min_val;
    logic [HOUR_W-1:0] hour_val;
    logic              sec_carry;
    logic              min_carry;
    logic              hour_carry_unused;

    logic [PW-1:0]     presc_q, presc_d;
    logic              pend_q, pend_d;
    logic              tick_q, tick_d;

    logic              alarm_sel;
    logic              edit_dir;
    logic              time_edit;
    logic              edit_sec, edit_min, edit_hour;
    logic              adv_req, adv_due, adv;
    logic              sec_inc, sec_dec;
    logic              min_inc, min_dec;
    logic              hour_inc, hour_dec;

`ifdef CLOCK_TIME_CORE_ALARM_EN
    assign alarm_sel = alarm_edit;
`else
    assign alarm_sel = 1'b0;
`endif

    // Exactly one of up/down must be high for an edit to count.
    assign edit_dir  = up ^ down;
    assign time_edit = edit_dir & (cursor_pos != FLD_NONE) & ~alarm_sel;
    assign edit_sec  = time_edit & (cursor_pos == FLD_SEC);
    assign edit_min  = time_edit & (cursor_pos == FLD_MIN);
    assign edit_hour = time_edit & (cursor_pos == FLD_HOUR);

    // A time edit steals the cycle from an advance; the advance is parked
    // in pend_q and replayed on the next cycle without an edit.
    assign adv_req = (presc_q == PRESC_TC);
    assign adv_due = adv_req | pend_q;
    assign adv     = adv_due & ~time_edit & ~clr;

    // adv and time_edit are exclusive, so carries only chain on advances.
    assign sec_inc  = adv | (edit_sec & up);
    assign sec_dec  = edit_sec & down;
    assign min_inc  = (adv & sec_carry) | (edit_min & up);
    assign min_dec  = edit_min & down;
    assign hour_inc = (adv & sec_carry & min_carry) | (edit_hour & up);
    assign hour_dec = edit_hour & down;

    wrap_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_inc),
        .dec   (sec_dec),
        .clr   (clr),
        .val   (sec_val),
        .carry (sec_carry)
    );

    wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .dec   (min_dec),
        .clr   (clr),
        .val   (min_val),
        .carry (min_carry)
    );

    wrap_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk   (clk),
        .reset (reset),
        .inc   (hour_inc),
        .dec   (hour_dec),
        .clr   (clr),
        .val   (hour_val),
        .carry (hour_carry_unused)
    );

    always_comb begin
        presc_d = presc_q + 1'b1;
        // Editing seconds restarts the second so the new value is held a
        // full period before the next advance.
        if (clr || edit_sec || adv_req) begin
            presc_d = '0;
        end
        pend_d = clr ? 1'b0 : (adv_due & time_edit);
        tick_d = adv;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            pend_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
        end
    end

    // Display mapping is combinational on the stored 24h value so mode12
    // never touches the stored time and takes effect immediately.
    assign second = sec_val;
    assign minute = min_val;
    assign hour   = mode12 ? to_hour12(hour_val) : hour_val;
    assign pm     = (hour_val >= NOON);
    assign tick   = tick_q;

`ifdef CLOCK_TIME_CORE_ALARM_EN
    logic [MIN_W-1:0]  alm_min_val;
    logic [HOUR_W-1:0] alm_hour_val;
    logic [MIN_W-1:0]  nxt_min;
    logic [HOUR_W-1:0] nxt_hour;
    logic              alm_edit;
    logic              alm_min_carry_unused;
    logic              alm_hour_carry_unused;
    logic              alarm_hit;
    logic              alarm_q, alarm_d;
    logic [5:0]        alarm_cnt_q, alarm_cnt_d;

    assign alm_edit = alarm_edit & edit_dir;

    wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_alm_min (
        .clk   (clk),
        .reset (reset),
        .inc   (alm_edit & up & (cursor_pos == FLD_MIN)),
        .dec   (alm_edit & down & (cursor_pos == FLD_MIN)),
        .clr   (1'b0),
        .val   (alm_min_val),
        .carry (alm_min_carry_unused)
    );

    wrap_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_alm_hour (
        .clk   (clk),
        .reset (reset),
        .inc   (alm_edit & up & (cursor_pos == FLD_HOUR)),
        .dec   (alm_edit & down & (cursor_pos == FLD_HOUR)),
        .clr   (1'b0),
        .val   (alm_hour_val),
        .carry (alm_hour_carry_unused)
    );

    // Time after a second rollover (only consulted when sec_carry fires).
    always_comb begin
        nxt_min  = (min_val == MIN_MAX) ? '0 : min_val + 1'b1;
        nxt_hour = hour_val;
        if (min_val == MIN_MAX) begin
            nxt_hour = (hour_val == HOUR_MAX) ? '0 : hour_val + 1'b1;
        end
    end

    assign alarm_hit = adv & sec_carry & (nxt_min == alm_min_val) &
                       (nxt_hour == alm_hour_val);

    // alarm_cnt_q counts down the advances left before self-silencing.
    always_comb begin
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        if (alarm_ack || !alarm_arm) begin
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
        end else if (alarm_hit) begin
            alarm_d     = 1'b1;
            alarm_cnt_d = ALARM_ADVANCES;
        end else if (alarm_q && adv) begin
            if (alarm_cnt_q == 6'd1) begin
                alarm_d     = 1'b0;
                alarm_cnt_d = '0;
            end else begin
                alarm_cnt_d = alarm_cnt_q - 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign alarm        = alarm_q;
    assign alarm_hour   = alm_hour_val;
    assign alarm_minute = alm_min_val;
`else
    logic alarm_inputs_unused;
    assign alarm_inputs_unused = alarm_edit ^ alarm_arm ^ alarm_ack;

    assign alarm        = 1'b0;
    assign alarm_hour   = '0;
    assign alarm_minute = '0;
`endif

endmodule

// File: tb/tb_clock_time_core.sv
// ---------------------------------------------------------------------------
// tb_clock_time_core
// Directed scenarios plus randomized stimulus against a seconds-of-day
// reference model; DUT outputs compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_clock_time_core;

    localparam int DIV = 10;
`ifdef CLOCK_TIME_CORE_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       mode12;
    logic       up;
    logic       down;
    logic       clr;
    logic [1:0] cursor_pos;
    logic       alarm_edit;
    logic       alarm_arm;
    logic       alarm_ack;
    logic [5:0] second;
    logic [5:0] minute;
    logic [4:0] hour;
    logic       pm;
    logic       tick;
    logic       alarm;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_minute;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // reference model state
    int m_sec, m_min, m_hr, m_presc, m_acnt, m_ah, m_am;
    bit m_pend, m_tick, m_alarm;

    clock_time_core #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .mode12       (mode12),
        .up           (up),
        .down         (down),
        .clr          (clr),
        .cursor_pos   (cursor_pos),
        .alarm_edit   (alarm_edit),
        .alarm_arm    (alarm_arm),
        .alarm_ack    (alarm_ack),
        .second       (second),
        .minute       (minute),
        .hour         (hour),
        .pm           (pm),
        .tick         (tick),
        .alarm        (alarm),
        .alarm_hour   (alarm_hour),
        .alarm_minute (alarm_minute)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int disp_hour(input int h, input bit m12);
        if (!m12) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic model_reset();
        m_sec = 0; m_min = 0; m_hr = 0; m_presc = 0; m_acnt = 0;
        m_ah = 0; m_am = 0; m_pend = 0; m_tick = 0; m_alarm = 0;
    endtask

    // One rising edge of behaviour, computed from the inputs of the cycle.
    task automatic model_step();
        bit aed, ed, due, adv, hit;
        int d, tod, ntod;
        if (reset) begin
            model_reset();
            return;
        end
        aed  = ALARM_EN && alarm_edit;
        ed   = (up != down) && (cursor_pos != 2'd3) && !aed;
        d    = up ? 1 : -1;
        due  = (m_presc == DIV - 1) || m_pend;
        adv  = due && !ed && !clr;
        tod  = m_hr * 3600 + m_min * 60 + m_sec;
        ntod = (tod + 1) % 86400;
        hit  = ALARM_EN && adv && (ntod == m_ah * 3600 + m_am * 60);
        if (ALARM_EN) begin
            if (alarm_ack || !alarm_arm) begin
                m_alarm = 0;
            end else if (hit) begin
                m_alarm = 1;
                m_acnt  = 0;
            end else if (m_alarm && adv) begin
                m_acnt++;
                if (m_acnt == 60) m_alarm = 0;
            end
            if (aed && (up != down)) begin
                if (cursor_pos == 2'd1) m_am = (m_am + d + 60) % 60;
                else if (cursor_pos == 2'd2) m_ah = (m_ah + d + 24) % 24;
            end
        end
        if (clr) begin
            m_sec = 0; m_min = 0; m_hr = 0; m_presc = 0; m_pend = 0; m_tick = 0;
        end else begin
            m_tick  = adv;
            m_pend  = due && ed;
            m_presc = ((m_presc == DIV - 1) || (ed && cursor_pos == 2'd0)) ? 0 : m_presc + 1;
            if (ed) begin
                case (cursor_pos)
                    2'd0:    m_sec = (m_sec + d + 60) % 60;
                    2'd1:    m_min = (m_min + d + 60) % 60;
                    default: m_hr  = (m_hr + d + 24) % 24;
                endcase
            end else if (adv) begin
                m_hr  = ntod / 3600;
                m_min = (ntod / 60) % 60;
                m_sec = ntod % 60;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("second", second, m_sec);
            chk("minute", minute, m_min);
            chk("hour", hour, disp_hour(m_hr, mode12));
            chk("pm", pm, (m_hr >= 12) ? 1 : 0);
            chk("tick", tick, m_tick);
            chk("alarm", alarm, m_alarm);
            chk("alarm_hour", alarm_hour, m_ah);
            chk("alarm_minute", alarm_minute, m_am);
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        up = 0; down = 0; clr = 0; cursor_pos = 2'd3; alarm_edit = 0; alarm_ack = 0;
    endtask

    task automatic pulse(input logic u, input logic dn, input logic [1:0] pos, input logic aed);
        up = u; down = dn; cursor_pos = pos; alarm_edit = aed;
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic do_clr();
        clr = 1;
        cyc();
        clr = 0;
    endtask

    task automatic wait_tick(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            seen = tick;
        end
        chk(name, seen, 1);
    endtask

    initial begin
        int tcnt, n, r;
        bit found;
        reset = 0; mode12 = 1; alarm_arm = 1;
        idle_inputs();
        model_reset();

        // reset value with 12-hour display
        #1;
        reset = 1;
        model_reset();
        #1;
        chk("rst_hour12", hour, 12);
        chk("rst_pm", pm, 0);
        chk("rst_second", second, 0);
        chk("rst_minute", minute, 0);
        cmp_en = 1;
        cyc();
        cyc();
        mode12 = 0;
        reset = 0;

        // ten clocks -> one advance
        tcnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (tick) tcnt++;
        end
        chk("first_tick_count", tcnt, 1);
        chk("first_second", second, 1);
        chk("first_minute", minute, 0);
        chk("first_hour", hour, 0);
        chk("model_first_second", m_sec, 1);

        // 23:59:59 -> 00:00:00
        do_clr();
        pulse(0, 1, 2'd0, 0);
        pulse(0, 1, 2'd1, 0);
        pulse(0, 1, 2'd2, 0);
        chk("preset_hour", hour, 23);
        chk("preset_second", second, 59);
        mode12 = 1;
        wait_tick("midnight_tick");
        chk("midnight_second", second, 0);
        chk("midnight_minute", minute, 0);
        chk("midnight_hour12", hour, 12);
        chk("midnight_pm", pm, 0);
        chk("model_midnight_hr", m_hr, 0);

        // 13:05 with mode switch
        mode12 = 0;
        do_clr();
        for (int i = 0; i < 11; i++) pulse(0, 1, 2'd2, 0);
        for (int i = 0; i < 5; i++) pulse(1, 0, 2'd1, 0);
        chk("h13_hour24", hour, 13);
        chk("h13_pm24", pm, 1);
        mode12 = 1;
        #1;
        chk("h13_hour12", hour, 1);
        chk("h13_pm12", pm, 1);
        chk("h13_minute", minute, 5);
        chk("model_h13_hr", m_hr, 13);
        mode12 = 0;

        // edit coincident with terminal count at 00:59:30
        do_clr();
        pulse(0, 1, 2'd1, 0);
        for (int i = 0; i < 70 && m_sec != 30; i++) pulse(1, 0, 2'd0, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_presc == DIV - 1) found = 1;
            else cyc();
        end
        chk("tc_reached", found, 1);
        up = 1; cursor_pos = 2'd1;
        cyc();
        idle_inputs();
        chk("coinc_second", second, 30);
        chk("coinc_minute", minute, 0);
        chk("coinc_hour", hour, 0);
        chk("coinc_tick", tick, 0);
        chk("model_coinc_sec", m_sec, 30);
        cyc();
        chk("pend_second", second, 31);
        chk("pend_tick", tick, 1);
        chk("pend_minute", minute, 0);
        down = 1; cursor_pos = 2'd1;
        cyc();
        idle_inputs();
        chk("min_down_wrap", minute, 59);
        chk("min_down_hour", hour, 0);

        // alarm at 07:30
        for (int i = 0; i < 7; i++) pulse(1, 0, 2'd2, 1);
        for (int i = 0; i < 30; i++) pulse(0, 1, 2'd1, 1);
        do_clr();
        for (int i = 0; i < 7; i++) pulse(1, 0, 2'd2, 0);
        for (int i = 0; i < 29; i++) pulse(1, 0, 2'd1, 0);
        for (int i = 0; i < 70 && m_sec != 59; i++) pulse(0, 1, 2'd0, 0);
        wait_tick("alarm_tick");
        chk("alarm_set", alarm, ALARM_EN ? 1 : 0);
        chk("alarm_time_hour", hour, 7);
        chk("alarm_time_minute", minute, 30);
        chk("alarm_time_second", second, 0);
        chk("alarm_reg_minute", alarm_minute, ALARM_EN ? 30 : 0);
        chk("alarm_reg_hour", alarm_hour, ALARM_EN ? 7 : 0);
        alarm_ack = 1;
        cyc();
        alarm_ack = 0;
        chk("alarm_acked", alarm, 0);

        // alarm self-clears after 60 advances
        pulse(1, 0, 2'd1, 1);
        found = 0;
        for (int i = 0; i < 800 && !found; i++) begin
            cyc();
            found = m_tick && (m_sec == 0);
        end
        chk("rollover_seen", found, 1);
        chk("alarm_set2", alarm, ALARM_EN ? 1 : 0);
        n = 0;
        found = 0;
        for (int i = 0; i < 800 && !found; i++) begin
            cyc();
            if (tick) n++;
            found = !alarm;
        end
        chk("alarm_duration", n, ALARM_EN ? 60 : 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            up = (r < 12);
            down = (r >= 8 && r < 20);
            cursor_pos = 2'($urandom_range(0, 3));
            alarm_edit = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 199) == 0);
            alarm_ack = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) alarm_arm = ~alarm_arm;
            if ($urandom_range(0, 29) == 0) mode12 = ~mode12;
            if ($urandom_range(0, 499) == 0) begin
                reset = 1;
                model_reset();
                cyc();
                reset = 0;
            end else begin
                cyc();
            end
        end
        idle_inputs();
        cyc();
        cmp_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_time_core.md
CLOCK_TIME_CORE -- requirements
Module: clock_time_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000: input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1: time-advance rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer of at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; one clock for the whole block, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port mode12, input, 1: 1 = 12-hour display, 0 = 24-hour display.
REQ-006 SHALL have ports up and down, input, 1 each: single-cycle edit pulses.
REQ-007 SHALL have port clr, input, 1: single-cycle pulse that synchronously clears the time.
REQ-008 SHALL have port cursor_pos, input, 2: edit field select; 0 = sec, 1 = min, 2 = hour, 3 = none.
REQ-009 SHALL have port alarm_edit, input, 1: 1 redirects edits to the alarm registers.
REQ-010 SHALL have port alarm_arm, input, 1: alarm enable.
REQ-011 SHALL have port alarm_ack, input, 1: pulse that silences the alarm.
REQ-012 SHALL have ports second and minute, output, 6 each: registered display values.
REQ-013 SHALL have port hour, output, 5: registered display hour.
REQ-014 SHALL have ports pm and tick, output, 1 each; tick is a one-cycle pulse per time advance.
REQ-015 SHALL have ports alarm, output, 1, and alarm_hour, output, 5, and alarm_minute, output, 6.

Function
REQ-016 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 and wrap; terminal count raises an internal advance request.
REQ-017 An advance SHALL increment sec 0..59; 59->0 SHALL carry to min 0..59; 59->0 SHALL carry to hour24 0..23; 23:59:59 SHALL become 00:00:00.
REQ-018 Outputs SHALL update on the clock edge after the advance request, and tick SHALL pulse high in that same cycle.
REQ-019 up on a field selected by cursor_pos 0-2 SHALL add 1 to that field with wrap at its limit and no carry; down SHALL subtract 1 with wrap (0->59, 0->23) and no borrow.
REQ-020 up and down both high, or cursor_pos=3, SHALL cause no edit.
REQ-021 An edit on the sec field SHALL also zero the prescaler.
REQ-022 When an edit and an advance request coincide, the edit SHALL apply; the advance SHALL be held in a pending flag and applied the next cycle, with tick pulsing then; no advance SHALL be lost.
REQ-023 clr SHALL zero time, prescaler and pending flag next edge, with priority over edit and advance; alarm registers SHALL be unaffected.
REQ-024 hour SHALL equal hour24 when mode12=0.
REQ-025 When mode12=1, hour SHALL map hour24 0 to 12, 1-12 to itself, and 13-23 to hour24-12.
REQ-026 pm SHALL be 1 when hour24 >= 12, in both modes.
REQ-027 mode12 SHALL affect display mapping only and never the stored time.

Reset
REQ-028 Asserting reset SHALL immediately zero sec, min, hour24, prescaler, pending flag, tick, alarm and alarm registers.
REQ-029 Under reset with mode12=1, the outputs SHALL read hour=12, pm=0, second=0, minute=0.
REQ-030 Reset mid-edit or mid-carry SHALL leave no partial update; counting SHALL resume from 00:00:00 on the first edge after deassertion.

Configuration
REQ-031 Macro CLOCK_TIME_CORE_ALARM_EN defined SHALL enable the alarm feature described in REQ-032 to REQ-035.
REQ-032 With alarm_edit=1, up/down on cursor_pos 1/2 SHALL edit alarm_minute/alarm_hour (24-h, wrap rules of REQ-019); cursor_pos 0 SHALL be ignored; time SHALL not be edited.
REQ-033 alarm SHALL set on the advance that produces hour24=alarm_hour, min=alarm_minute, sec=0 while alarm_arm=1.
REQ-034 alarm SHALL clear on alarm_ack, on alarm_arm=0, or after 60 advances; set and ack in the same cycle SHALL result in alarm=0.
REQ-035 Macro undefined SHALL keep all ports present, with alarm, alarm_hour and alarm_minute tied to 0, alarm_edit treated as 0, and alarm inputs ignored.

Structure
REQ-036 A shared package clock_pkg SHALL hold field-index constants (FLD_SEC, FLD_MIN, FLD_HOUR, FLD_NONE), limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, and field widths.
REQ-037 Sub-module wrap_counter (parameters MAX and W; inputs inc, dec, clr; outputs val and carry) SHALL be instantiated for sec, min, hour and alarm fields.

Verification (CLK_HZ=10, TICK_HZ=1)
REQ-038 Reset, run 10 clocks -> tick once; second=1, minute=0, hour=0.
REQ-039 Preset 23:59:59 via edits, one advance -> 00:00:00, tick=1; with mode12=1 hour=12, pm=0.
REQ-040 Time 13:05:00, mode12 toggled 0->1 -> hour 13->1, pm stays 1, minute=5 unchanged.
REQ-041 up on cursor_pos=1 coincident with terminal count at 00:59:30 -> next edge 00:00:30, following edge 00:00:31 with tick; down on min=0 -> 59, hour unchanged.
REQ-042 Alarm 07:30 armed, time 07:29:59, one advance -> alarm=1; alarm_ack -> alarm=0; macro undefined -> alarm stays 0.
